// File: rtl/result_accumulator.sv
// Accumulates COUNT consecutive 33-bit adder results into one saturating ACC_W-bit
// frame sum and hands each completed frame off over a valid/ready handshake.
module result_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [32:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      frame_cnt
);

  localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;

  logic [ACC_W:0]   sum_s;
  logic             sat_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             last_s;

  // Next accumulator value and saturation status for a sample accepted this cycle
  always_comb begin
    sum_s = {1'b0, acc_r} + {{(ACC_W - 32){1'b0}}, in_data};
    sat_s = sum_s[ACC_W] | ovf_r;
    if (sat_s) begin
      acc_nxt_s = {ACC_W{1'b1}};
    end else begin
      acc_nxt_s = sum_s[ACC_W-1:0];
    end
    last_s = (cnt_r == CNT_W'(COUNT - 1));
  end

  // in_ready depends only on state so the consumer's out_ready never reaches it
  assign in_ready = (state_r == ST_ACC);

  // Frame FSM, accumulator and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_ACC;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
      out_data  <= {ACC_W{1'b0}};
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
      frame_cnt <= 16'd0;
    end else if (clr) begin
      state_r   <= ST_ACC;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (in_valid) begin
            acc_r <= acc_nxt_s;
            ovf_r <= sat_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_s) begin
              out_data  <= acc_nxt_s;
              out_ovf   <= sat_s;
              out_valid <= 1'b1;
              state_r   <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Handoff cycle: frame is released and no input is taken
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_r     <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            state_r   <= ST_ACC;
          end
        end
        default: begin
          state_r   <= ST_ACC;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_accumulator.sv
// Directed plus randomized bench for result_accumulator; ACC_W=36 and ACC_W=34 instances
// share one stimulus stream and are checked against a plain-arithmetic frame model.
module tb_result_accumulator;

  localparam int COUNT = 4;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [32:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_a, out_ovf_a, out_valid_a;
  logic [35:0] out_data_a;
  logic [15:0] frame_cnt_a;
  logic        in_ready_b, out_ovf_b, out_valid_b;
  logic [33:0] out_data_b;
  logic [15:0] frame_cnt_b;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [32:0] fq[$];

  result_accumulator #(.COUNT(COUNT), .ACC_W(36)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_ovf(out_ovf_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .frame_cnt(frame_cnt_a)
  );

  result_accumulator #(.COUNT(COUNT), .ACC_W(34)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_ovf(out_ovf_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .frame_cnt(frame_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired before the end of the run");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame sum from the accepted samples: add until the width is exceeded, then pin to max
  function automatic logic [64:0] model(input int w);
    longint unsigned s;
    longint unsigned mx;
    bit              sat;
    s   = 64'd0;
    sat = 1'b0;
    mx  = (64'd1 << w) - 64'd1;
    foreach (fq[i]) begin
      if (!sat) begin
        s = s + 64'(fq[i]);
        if (s > mx) sat = 1'b1;
      end
    end
    if (sat) s = mx;
    return {sat, s};
  endfunction

  function automatic logic [32:0] rnd33();
    logic [32:0] v;
    case ($urandom_range(0, 2))
      0: v = 33'($urandom_range(0, 255));
      1: v = 33'h1_FFFF_FFFF - 33'($urandom_range(0, 255));
      default: v = {1'($urandom_range(0, 1)), 32'($urandom)};
    endcase
    return v;
  endfunction

  task automatic push(input logic [32:0] v, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    while (!(in_ready_a && in_ready_b) && n < 20) begin
      step();
      n++;
    end
    check("push_ready_a", 64'(in_ready_a), 64'd1);
    check("push_ready_b", 64'(in_ready_b), 64'd1);
    step();
    in_valid = 1'b0;
    fq.push_back(v);
    if (fq.size() < COUNT) check("mid_frame_valid", 64'(out_valid_a), 64'd0);
  endtask

  task automatic frame4(input logic [32:0] v0, input logic [32:0] v1,
                        input logic [32:0] v2, input logic [32:0] v3, input int gap);
    push(v0, gap);
    push(v1, gap);
    push(v2, gap);
    push(v3, gap);
  endtask

  task automatic check_frame(input string tag);
    logic [64:0] ma;
    logic [64:0] mb;
    ma = model(36);
    mb = model(34);
    check({tag, "_valid_a"}, 64'(out_valid_a), 64'd1);
    check({tag, "_valid_b"}, 64'(out_valid_b), 64'd1);
    check({tag, "_data_a"}, 64'(out_data_a), ma[63:0]);
    check({tag, "_ovf_a"}, 64'(out_ovf_a), 64'(ma[64]));
    check({tag, "_data_b"}, 64'(out_data_b), mb[63:0]);
    check({tag, "_ovf_b"}, 64'(out_ovf_b), 64'(mb[64]));
  endtask

  task automatic handoff(input string tag, input int hold);
    logic [64:0] ma;
    ma = model(36);
    out_ready = 1'b0;
    repeat (hold) begin
      step();
      check({tag, "_hold_valid"}, 64'(out_valid_a), 64'd1);
      check({tag, "_hold_data"}, 64'(out_data_a), ma[63:0]);
      check({tag, "_hold_ready"}, 64'(in_ready_a), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_fc    = exp_fc + 16'd1;
    check({tag, "_post_valid"}, 64'(out_valid_a), 64'd0);
    check({tag, "_post_ready"}, 64'(in_ready_a), 64'd1);
    check({tag, "_fc_a"}, 64'(frame_cnt_a), 64'(exp_fc));
    check({tag, "_fc_b"}, 64'(frame_cnt_b), 64'(exp_fc));
    fq.delete();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_data = 33'd0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset
    step();
    step();
    check("rst_data", 64'(out_data_a), 64'd0);
    check("rst_ovf", 64'(out_ovf_a), 64'd0);
    check("rst_valid", 64'(out_valid_a), 64'd0);
    check("rst_fc", 64'(frame_cnt_a), 64'd0);
    rst = 1'b0;
    step();
    check("rst_ready", 64'(in_ready_a), 64'd1);

    // Basic frame, back-to-back
    frame4(33'd1, 33'd2, 33'd3, 33'd4, 0);
    check("basic_sum", 64'(out_data_a), 64'd10);
    check_frame("basic");
    handoff("basic", 0);

    // Max inputs: 36-bit fits, 34-bit saturates on the third accept
    frame4(33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 0);
    check("max_a", 64'(out_data_a), 64'h7_FFFF_FFFC);
    check("sat_b", 64'(out_data_b), 64'h3_FFFF_FFFF);
    check("sat_b_ovf", 64'(out_ovf_b), 64'd1);
    check_frame("max");
    handoff("max", 0);
    frame4(33'd1, 33'd1, 33'd1, 33'd1, 0);
    check("after_sat_b", 64'(out_data_b), 64'd4);
    check("after_sat_ovf", 64'(out_ovf_b), 64'd0);
    check_frame("after_sat");
    handoff("after_sat", 0);

    // Backpressure with in_valid held high during HOLD and handoff
    frame4(33'd5, 33'd5, 33'd5, 33'd5, 0);
    check("bp_sum", 64'(out_data_a), 64'd20);
    check_frame("bp");
    in_valid = 1'b1;
    in_data  = 33'd3;
    handoff("bp", 6);
    frame4(33'd7, 33'd0, 33'd0, 33'd1, 0);
    check("bp_next", 64'(out_data_a), 64'd8);
    check_frame("bp_next");
    handoff("bp_next", 1);

    // Clear mid-frame, with a sample offered during the clear cycle
    push(33'd9, 0);
    push(33'd9, 0);
    clr = 1'b1; in_valid = 1'b1; in_data = 33'd50;
    step();
    clr = 1'b0; in_valid = 1'b0;
    fq.delete();
    frame4(33'd2, 33'd2, 33'd2, 33'd2, 0);
    check("clr_sum", 64'(out_data_a), 64'd8);
    check_frame("clr");
    handoff("clr", 0);

    // Clear in HOLD coincident with out_ready: frame discarded, not counted
    frame4(33'd11, 33'd12, 33'd13, 33'd14, 0);
    check_frame("clr_hold");
    clr = 1'b1; out_ready = 1'b1;
    step();
    clr = 1'b0; out_ready = 1'b0;
    check("clr_hold_valid", 64'(out_valid_a), 64'd0);
    check("clr_hold_fc", 64'(frame_cnt_a), 64'(exp_fc));
    check("clr_hold_ready", 64'(in_ready_a), 64'd1);
    fq.delete();

    // Sparse input
    frame4(33'd1, 33'd0, 33'd1, 33'd0, 1);
    check("sparse_sum", 64'(out_data_a), 64'd2);
    check_frame("sparse");
    handoff("sparse", 0);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < COUNT; k++) push(rnd33(), int'($urandom_range(0, 2)));
      check_frame("rand");
      handoff("rand", int'($urandom_range(0, 3)));
    end

    // frame_cnt wrap
    force dut_a.frame_cnt = 16'hFFFF;
    force dut_b.frame_cnt = 16'hFFFF;
    #1;
    release dut_a.frame_cnt;
    release dut_b.frame_cnt;
    exp_fc = 16'hFFFF;
    frame4(33'd3, 33'd3, 33'd3, 33'd3, 0);
    check_frame("wrap");
    handoff("wrap", 0);
    check("wrap_zero", 64'(frame_cnt_a), 64'd0);

    // Reset mid-frame clears everything including frame_cnt
    push(33'd100, 0);
    push(33'd200, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_fc = 16'd0;
    fq.delete();
    check("rst_mid_fc", 64'(frame_cnt_a), 64'd0);
    check("rst_mid_valid", 64'(out_valid_a), 64'd0);
    check("rst_mid_ready", 64'(in_ready_a), 64'd1);
    frame4(33'd1, 33'd2, 33'd3, 33'd4, 0);
    check("rst_mid_sum", 64'(out_data_a), 64'd10);
    check_frame("rst_mid");
    handoff("rst_mid", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
